// File: rtl/cpu_wb_pipe_cla_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_wb_pipe_cla_adder_if
// Brief    : Operand/result handshake bundle for the pipelined CLA adder.
// Revision : 1.0 - initial release
// ============================================================================
interface cpu_wb_pipe_cla_adder_if #(
    parameter int DATA_WID = 32
);
    logic                in_valid;
    logic                in_ready;
    logic [DATA_WID-1:0] in1;
    logic [DATA_WID-1:0] in2;
    logic                carry_in;
    logic                sub;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_WID-1:0] sum;
    logic                carry_out;
    logic                overflow;
    logic                zero;

    modport slave (
        input  in_valid, in1, in2, carry_in, sub, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow, zero
    );

    modport master (
        output in_valid, in1, in2, carry_in, sub, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow, zero
    );
endinterface
`default_nettype wire

// File: rtl/cpu_wb_pipe_cla_adder.sv
`default_nettype none
// ============================================================================
// Module   : cpu_wb_pipe_cla_adder
// Brief    : Pipelined block carry-lookahead adder/subtractor, one block per stage.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_wb_pipe_cla_adder #(
    parameter int DATA_WID = 32,
    parameter int BLK_WID  = 8
) (
    input  wire                     clk,
    input  wire                     rst_n,
    cpu_wb_pipe_cla_adder_if.slave  bus
);
    localparam int NUM_STG = DATA_WID / BLK_WID;

    if ((DATA_WID % BLK_WID) != 0 || DATA_WID < BLK_WID) begin : g_bad_param
        $error("DATA_WID must be a non-zero integer multiple of BLK_WID");
    end

    // Flattened lookahead: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
    function automatic logic [BLK_WID:0] cla_carry(
        input logic [BLK_WID-1:0] g,
        input logic [BLK_WID-1:0] p,
        input logic               cin
    );
        logic [BLK_WID:0] c;
        logic             term;
        logic             prop;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < BLK_WID; i++) begin
            term = g[i];
            prop = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                term = term | (prop & g[j]);
                prop = prop & p[j];
            end
            c[i+1] = term | (prop & cin);
        end
        return c;
    endfunction

    logic                adv;
    logic                out_valid_q;
    logic [DATA_WID-1:0] sum_q;
    logic                carry_out_q;
    logic                overflow_q;
    logic                zero_q;

    // Stage inputs: index 0 comes from the ports, index k from stage k-1.
    logic                stg_v [NUM_STG];
    logic                stg_c [NUM_STG];
    logic [DATA_WID-1:0] stg_a [NUM_STG];
    logic [DATA_WID-1:0] stg_b [NUM_STG];
    logic [DATA_WID-1:0] stg_s [NUM_STG];

    assign adv          = ~out_valid_q | bus.out_ready;
    assign bus.in_ready = adv;

    assign stg_v[0] = bus.in_valid;
    assign stg_c[0] = bus.carry_in;
    assign stg_a[0] = bus.in1;
    assign stg_b[0] = bus.sub ? ~bus.in2 : bus.in2;
    assign stg_s[0] = '0;

    for (genvar k = 0; k < NUM_STG; k++) begin : g_stg
        logic [BLK_WID-1:0]  blk_a;
        logic [BLK_WID-1:0]  blk_b;
        logic [BLK_WID-1:0]  blk_s;
        logic [BLK_WID:0]    blk_c;
        logic [DATA_WID-1:0] s_d;

        always_comb begin
            blk_a = stg_a[k][k*BLK_WID +: BLK_WID];
            blk_b = stg_b[k][k*BLK_WID +: BLK_WID];
            blk_c = cla_carry(blk_a & blk_b, blk_a | blk_b, stg_c[k]);
            blk_s = blk_a ^ blk_b ^ blk_c[BLK_WID-1:0];
            s_d   = stg_s[k] | (DATA_WID'(blk_s) << (k * BLK_WID));
        end

        if (k < NUM_STG - 1) begin : g_mid
            logic                v_q;
            logic                c_q;
            logic [DATA_WID-1:0] a_q;
            logic [DATA_WID-1:0] b_q;
            logic [DATA_WID-1:0] s_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    v_q <= 1'b0;
                    c_q <= 1'b0;
                    a_q <= '0;
                    b_q <= '0;
                    s_q <= '0;
                end else if (adv) begin
                    v_q <= stg_v[k];
                    c_q <= blk_c[BLK_WID];
                    a_q <= stg_a[k];
                    b_q <= stg_b[k];
                    s_q <= s_d;
                end
            end

            assign stg_v[k+1] = v_q;
            assign stg_c[k+1] = c_q;
            assign stg_a[k+1] = a_q;
            assign stg_b[k+1] = b_q;
            assign stg_s[k+1] = s_q;
        end else begin : g_last
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    out_valid_q <= 1'b0;
                    sum_q       <= '0;
                    carry_out_q <= 1'b0;
                    overflow_q  <= 1'b0;
                    zero_q      <= 1'b0;
                end else if (adv) begin
                    out_valid_q <= stg_v[k];
                    sum_q       <= s_d;
                    carry_out_q <= blk_c[BLK_WID];
                    overflow_q  <= blk_c[BLK_WID] ^ blk_c[BLK_WID-1];
                    zero_q      <= (s_d == '0);
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.carry_out = carry_out_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;
endmodule
`default_nettype wire
